pm_ctrl: RTL

Program-sequencing and decode stage for the picoMips core. Holds the program counter, addresses the program ROM, and decodes each 16-bit instruction into the accumulator-ALU controls and register-file controls. It also sequences a switch-operated WAIT handshake and a terminal HALT. The block sits directly upstream of the ALU and drives every ALU select and enable, plus the immediate.

---
 rtl/pm_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pm_ctrl.sv
// pm_ctrl: program sequencing and instruction decode for the picoMips core.
//
// Holds the program counter, addresses the program ROM and decodes each
// 16-bit instruction into accumulator-ALU and register-file controls. Also
// sequences a push-button WAIT handshake and a terminal HALT.
//
// Ports:
//   Clock       in   system clock, rising edge
//   nReset      in   asynchronous active-low reset
//   Instr[15:0] in   ROM[PC]: [15:12] opcode, [11:8] RegAddr, [7:0] Imm
//   ACC[7:0]    in   accumulator value, used for branch conditions
//   Go          in   asynchronous push-button, synchronised internally
//   PC          out  program counter / ROM address
//   Imm         out  Instr[7:0]
//   RegAddr     out  Instr[11:8]
//   RegWE       out  register-file write enable (RF[RegAddr] = ACC)
//   WE          out  accumulator write enable
//   SelImm, SelSW, SelRegData  out  ALU data-source selects (one-hot or zero)
//   UseACC      out  ALU uses ACC as an operand
//   UseMul      out  ALU multiplies by Imm
//   Halted      out  high in state HALT
module pm_ctrl #(
  parameter int unsigned PCWidth = 8  // branch targets come from Imm, so <= 8
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic [15:0]        Instr,
  input  logic [7:0]         ACC,
  input  logic               Go,
  output logic [PCWidth-1:0] PC,
  output logic [7:0]         Imm,
  output logic [3:0]         RegAddr,
  output logic               RegWE,
  output logic               WE,
  output logic               SelImm,
  output logic               SelSW,
  output logic               SelRegData,
  output logic               UseACC,
  output logic               UseMul,
  output logic               Halted
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] WAIT_HI = 2'd1;
  localparam logic [1:0] WAIT_LO = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_LDSW = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_ADDR = 4'h5;
  localparam logic [3:0] OP_MULI = 4'h6;
  localparam logic [3:0] OP_MADD = 4'h7;
  localparam logic [3:0] OP_STR  = 4'h8;
  localparam logic [3:0] OP_BRZ  = 4'h9;
  localparam logic [3:0] OP_BRN  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_WAIT = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [PCWidth-1:0] r_pc;
  logic [PCWidth-1:0] w_pc_nxt;
  logic [PCWidth-1:0] w_pc_inc;
  logic               r_go_meta;
  logic               r_go_sync;

  logic [3:0] w_op;
  logic       w_we;
  logic       w_regwe;
  logic       w_take;
  logic       w_run;

  assign w_op     = Instr[15:12];
  assign w_run    = (r_state == RUN);
  assign w_pc_inc = r_pc + PCWidth'(1);

  // Instruction decode, purely combinational from Instr.
  always_comb begin
    w_we       = 1'b0;
    w_regwe    = 1'b0;
    SelImm     = 1'b0;
    SelSW      = 1'b0;
    SelRegData = 1'b0;
    UseACC     = 1'b0;
    UseMul     = 1'b0;
    w_take     = 1'b0;
    case (w_op)
      OP_LDI:  begin w_we = 1'b1; SelImm = 1'b1; end
      OP_LDR:  begin w_we = 1'b1; SelRegData = 1'b1; end
      OP_LDSW: begin w_we = 1'b1; SelSW = 1'b1; end
      OP_ADDI: begin w_we = 1'b1; UseACC = 1'b1; SelImm = 1'b1; end
      OP_ADDR: begin w_we = 1'b1; UseACC = 1'b1; SelRegData = 1'b1; end
      OP_MULI: begin w_we = 1'b1; UseACC = 1'b1; UseMul = 1'b1; end
      OP_MADD: begin w_we = 1'b1; UseACC = 1'b1; SelRegData = 1'b1; UseMul = 1'b1; end
      OP_STR:  w_regwe = 1'b1;
      OP_BRZ:  w_take = (ACC == 8'h00);
      OP_BRN:  w_take = ACC[7];
      OP_JMP:  w_take = 1'b1;
      default: ;  // NOP, WAIT, HALT and unused D/E assert nothing here
    endcase
  end

  // Writes are suppressed during reset and outside RUN so that a stalled or
  // halted instruction never commits repeatedly.
  assign WE      = nReset & w_run & w_we;
  assign RegWE   = nReset & w_run & w_regwe;
  assign Imm     = Instr[7:0];
  assign RegAddr = Instr[11:8];
  assign PC      = r_pc;
  assign Halted  = (r_state == HALT);

  // Next state / next PC.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      RUN: begin
        if (w_op == OP_WAIT) begin
          w_state_nxt = WAIT_HI;
        end else if (w_op == OP_HALT) begin
          w_state_nxt = HALT;
        end else if (w_take) begin
          w_pc_nxt = Imm[PCWidth-1:0];
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      WAIT_HI: begin
        if (r_go_sync) w_state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        // Release completes the handshake and steps past the WAIT.
        if (!r_go_sync) begin
          w_state_nxt = RUN;
          w_pc_nxt    = w_pc_inc;
        end
      end
      default: ;  // HALT is left only by reset
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state   <= RUN;
      r_pc      <= '0;
      r_go_meta <= 1'b0;
      r_go_sync <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_go_meta <= Go;
      r_go_sync <= r_go_meta;
    end
  end

endmodule
